// File: rtl/riscv_mmio_console.sv
// riscv_mmio_console
//   Memory-mapped console / test-status peripheral on the core data bus.
//   Firmware pushes bytes into a TX FIFO. A UART 8N1 transmitter drains the
//   FIFO. A TOHOST register raises done/pass flags that tell a bench when to
//   stop and whether the run passed.
//
// Ports
//   clk_i, reset_i     clock, asynchronous active-high reset
//   daddr_i, dwdata_i  data-bus byte address and write data
//   dsize_i            access size (not used by this block)
//   drd_i, dwr_i       single-cycle read / write strobes
//   drdata_o, sel_o    registered read data, and its qualifier one cycle later
//   txd_o              UART serial output, idle high
//   done_o, pass_o     sticky completion flag and the pass verdict
//   tohost_o           last value written to TOHOST
//
// Register window (16 bytes at BASE_ADDR, selected by daddr_i[3:2])
//   0x0 TXDATA   W: push byte.  R: 0
//   0x4 STATUS   R: {16'b0, count[7:0], 4'b0, overflow, busy, full, empty}
//                W: bit3=1 clears overflow
//   0x8 TOHOST   R/W 32-bit
//   0xC BAUD_DIV R/W [15:0]. A written 0 is stored as 1.
//
// Bus handshake: a strobe is a single-cycle request with no backpressure.
// A read with drd_i high at edge N produces sel_o=1 and drdata_o valid
// during the cycle after edge N. Writes take effect at the strobe edge.
module riscv_mmio_console #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] daddr_i,
  input  logic [31:0] dwdata_i,
  input  logic [1:0]  dsize_i,
  input  logic        drd_i,
  input  logic        dwr_i,
  output logic [31:0] drdata_o,
  output logic        sel_o,
  output logic        txd_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [31:0] tohost_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------- decode
  logic       hit;
  logic [1:0] reg_sel;
  logic       rd_hit;
  logic       wr_txdata, wr_status, wr_tohost, wr_baud;

  assign hit       = (daddr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_sel   = daddr_i[3:2];
  assign rd_hit    = drd_i && hit;
  assign wr_txdata = dwr_i && hit && (reg_sel == 2'd0);
  assign wr_status = dwr_i && hit && (reg_sel == 2'd1);
  assign wr_tohost = dwr_i && hit && (reg_sel == 2'd2);
  assign wr_baud   = dwr_i && hit && (reg_sel == 2'd3);

  // Size and byte offset play no role in this block's decode.
  logic unused_bits;
  assign unused_bits = ^{dsize_i, daddr_i[1:0]};

  // ------------------------------------------------------------- registers
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic          ovf_q;
  logic [31:0]   tohost_q;
  logic          done_q, pass_q;
  logic [15:0]   baud_q;
  logic [31:0]   rdata_q;
  logic          sel_q;

  state_e        state_q;
  logic [7:0]    shift_q;
  logic [15:0]   div_q;     // BAUD_DIV captured at pop, constant for the frame
  logic [15:0]   cnt_q;     // cycles left in the current bit, minus one
  logic [2:0]    bit_q;
  logic          txd_q;

  // ------------------------------------------------------------------ FIFO
  logic full, empty, busy;
  logic pop, push_ok;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign busy  = (state_q != S_IDLE);
  assign pop   = (state_q == S_IDLE) && !empty;
  // A pop in the same cycle frees a slot, so a push while full is accepted.
  assign push_ok = wr_txdata && (!full || pop);

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_q[wr_ptr_q] <= dwdata_i[7:0];
  end

  // ------------------------------------------------------------- read mux
  logic [31:0] rd_val;
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      2'd0: rd_val = '0;
      2'd1: rd_val = {16'b0, 8'(count_q), 4'b0, ovf_q, busy, full, empty};
      2'd2: rd_val = tohost_q;
      2'd3: rd_val = {16'b0, baud_q};
      default: rd_val = '0;
    endcase
  end

  // -------------------------------------------------------- register file
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      tohost_q <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      baud_q   <= DIV_RESET;
      rdata_q  <= '0;
      sel_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_txdata && full && !pop) ovf_q <= 1'b1;
      else if (wr_status && dwdata_i[3]) ovf_q <= 1'b0;
      if (wr_tohost) begin
        tohost_q <= dwdata_i;
        done_q   <= 1'b1;
        pass_q   <= (dwdata_i == 32'd1);
      end
      if (wr_baud) baud_q <= (dwdata_i[15:0] == 16'd0) ? 16'd1 : dwdata_i[15:0];
      // rd_val reflects pre-write state, so a simultaneous write is not seen.
      sel_q   <= rd_hit;
      rdata_q <= rd_hit ? rd_val : '0;
    end
  end

  // -------------------------------------------------------------- UART FSM
  // txd_q is a registered copy of the line level implied by the current
  // state, so the serial output lags the FSM by one cycle uniformly.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      div_q   <= 16'd1;
      cnt_q   <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        S_START: txd_q <= 1'b0;
        S_DATA:  txd_q <= shift_q[0];
        default: txd_q <= 1'b1;
      endcase

      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            shift_q <= fifo_q[rd_ptr_q];
            div_q   <= baud_q;
            cnt_q   <= baud_q - 16'd1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == 16'd0) begin
            cnt_q   <= div_q - 16'd1;
            bit_q   <= 3'd0;
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == 16'd0) begin
            cnt_q   <= div_q - 16'd1;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= S_STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == 16'd0) state_q <= S_IDLE;
          else                cnt_q   <= cnt_q - 16'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign drdata_o = rdata_q;
  assign sel_o    = sel_q;
  assign txd_o    = txd_q;
  assign done_o   = done_q;
  assign pass_o   = pass_q;
  assign tohost_o = tohost_q;

endmodule
